// File: rtl/fetch_unit_pkg.sv
// Shared configuration for the fetch stage: instruction/word widths, the NOP
// that fills an empty IF/ID slot, and the fetch state encoding.
package fetch_unit_pkg;

  localparam int XLEN       = 32;
  localparam int INST_WIDTH = 32;

  // addi x0, x0, 0
  localparam logic [INST_WIDTH-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } fetch_state_t;

  // A redirect target is usable only when it is word aligned.
  function automatic logic is_aligned(input logic [XLEN-1:0] addr);
    return (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/fetch_unit_if_id_reg.sv
// IF/ID pipeline register: valid bit, instruction word and its PC.
// Priority among the controls is trap > kill > load > hold.
// A trap kills the slot and records the faulting target in pc.
module if_id_reg
  import fetch_unit_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load,
  input  logic                  kill,
  input  logic                  trap,
  input  logic [INST_WIDTH-1:0] inst_d,
  input  logic [XLEN-1:0]       pc_d,
  input  logic [XLEN-1:0]       trap_pc,
  output logic                  valid,
  output logic [INST_WIDTH-1:0] inst,
  output logic [XLEN-1:0]       pc
);

  // Slot update: an empty slot always carries NOP so decode never sees stale bits.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= '0;
    end else if (trap) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
      pc    <= trap_pc;
    end else if (kill) begin
      valid <= 1'b0;
      inst  <= NOP_INST;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= inst_d;
      pc    <= pc_d;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage. Owns the PC, drives the instruction memory byte
// address and captures the returned word into the IF/ID register.
//
// Handshake: valid_o/ready_i follow valid/ready rules. The IF/ID slot is
// consumed on a cycle where valid_o && ready_i && !stall_i; while valid_o is
// high and the slot is not consumed, inst_o/pc_o are held stable. Redirect and
// flush may withdraw valid_o at any time (wrong-path kill).
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int           MEM_SIZE = 1024,
  parameter logic [31:0]  RESET_PC = 32'h0000_0000,
  localparam int          ADDR_W   = $clog2(MEM_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  redirect_i,
  input  logic [31:0]           redirect_pc_i,
  output logic [ADDR_W-1:0]     imem_addr_o,
  input  logic [INST_WIDTH-1:0] imem_inst_i,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [31:0]           pc_o,
  output logic [31:0]           pc_plus4_o,
  output logic                  misaligned_o,
  output logic [1:0]            dbg_state_o
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            adv;
  logic            load;
  logic            kill;
  logic            trap;

  // Memory is addressed straight from the PC; high bits alias.
  assign imem_addr_o  = pc_q[ADDR_W-1:0];
  assign pc_plus4_o   = pc_o + 32'd4;
  assign misaligned_o = (state_q == TRAP);
  assign dbg_state_o  = state_q;

  // PC and fetch state registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      pc_q    <= RESET_PC;
      state_q <= BOOT;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  // Next PC/state and IF/ID controls; redirect outranks everything but reset.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    load    = 1'b0;
    kill    = 1'b0;
    trap    = 1'b0;
    adv     = !stall_i && (!valid_o || ready_i);
    if (redirect_i) begin
      kill = 1'b1;
      if (is_aligned(redirect_pc_i)) begin
        pc_d    = redirect_pc_i;
        state_d = RUN;
      end else begin
        trap    = 1'b1;
        state_d = TRAP;
      end
    end else begin
      case (state_q)
        BOOT: begin
          kill    = flush_i;
          state_d = RUN;
        end
        RUN: begin
          kill = flush_i;
          if (adv) begin
            // A flushed fetch is discarded but the PC still moves on.
            load = !flush_i;
            pc_d = pc_q + 32'd4;
          end
        end
        TRAP: begin
          kill = 1'b1;
        end
        default: begin
          state_d = BOOT;
        end
      endcase
    end
  end

  if_id_reg u_if_id (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .load    (load),
    .kill    (kill),
    .trap    (trap),
    .inst_d  (imem_inst_i),
    .pc_d    (pc_q),
    .trap_pc (redirect_pc_i),
    .valid   (valid_o),
    .inst    (inst_o),
    .pc      (pc_o)
  );

endmodule
